// File: rtl/pipe_scheduler_if.sv
// pipe_scheduler_if: control, random-source handshake and pipe-state bundle of the pipe scheduler
interface pipe_scheduler_if #(
   parameter int NUM_PIPES = 3,
   parameter int X_W       = 10,
   parameter int GAP_W     = 9
);
   logic                       iStart;
   logic                       iFrame_Tick;
   logic                       iCollision;
   logic                       iRnd_Valid;
   logic [GAP_W-1:0]           iRnd_Data;
   logic                       oRnd_Req;
   logic [NUM_PIPES*X_W-1:0]   oPipe_X;
   logic [NUM_PIPES*GAP_W-1:0] oPipe_Gap;
   logic [NUM_PIPES-1:0]       oPipe_Active;
   logic                       oScore_Inc;
   logic [2:0]                 oSpeed;
   logic                       oRunning;
   logic                       oGame_Over;
   modport master (
      output iStart, iFrame_Tick, iCollision, iRnd_Valid, iRnd_Data,
      input  oRnd_Req, oPipe_X, oPipe_Gap, oPipe_Active, oScore_Inc, oSpeed, oRunning, oGame_Over
   );
   modport slave (
      input  iStart, iFrame_Tick, iCollision, iRnd_Valid, iRnd_Data,
      output oRnd_Req, oPipe_X, oPipe_Gap, oPipe_Active, oScore_Inc, oSpeed, oRunning, oGame_Over
   );
endinterface

// File: rtl/pipe_scheduler.sv
// pipe_scheduler: spawns, scrolls and retires pipe slots, fetching gap heights from a random source
module pipe_scheduler #(
   parameter int NUM_PIPES       = 3,
   parameter int X_W             = 10,
   parameter int GAP_W           = 9,
   parameter int SCREEN_W        = 640,
   parameter int SPACING         = 220,
   parameter int GAP_MAX         = 400,
   parameter int SPEED_INIT      = 1,
   parameter int SPEED_MAX       = 7,
   parameter int SCORE_PER_SPEED = 5
) (
   input logic             iClk,
   input logic             iRst,
   pipe_scheduler_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_PIPES);
   localparam int CNT_W = $clog2(SCORE_PER_SPEED + 1);
   typedef enum logic [1:0] {IDLE, RUN, SPAWN, OVER} state_t;
   state_t           state_q, state_d;
   logic [X_W-1:0]   x_q [NUM_PIPES];
   logic [X_W-1:0]   x_d [NUM_PIPES];
   logic [GAP_W-1:0] gap_q [NUM_PIPES];
   logic [GAP_W-1:0] gap_d [NUM_PIPES];
   logic [NUM_PIPES-1:0] act_q, act_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [IDX_W-1:0] free_idx;
   logic             has_free;
   logic             req_q, req_d;
   logic             inc_q, inc_d;
   logic [2:0]       spd_q, spd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [X_W-1:0]   spd_x;
   logic [GAP_W-1:0] gap_new;
   logic             live, accept, retire, spawn_due, wrap;
   assign spd_x     = X_W'(spd_q);
   assign gap_new   = (bus.iRnd_Data > GAP_W'(GAP_MAX)) ? GAP_W'(GAP_MAX) : bus.iRnd_Data;
   assign live      = (state_q == RUN) || (state_q == SPAWN);
   assign accept    = (state_q == SPAWN) && req_q && bus.iRnd_Valid;
   assign spawn_due = has_free && ((act_q == '0) || (x_q[last_q] <= X_W'(SCREEN_W - SPACING)));
   assign wrap      = cnt_q == CNT_W'(SCORE_PER_SPEED - 1);
   // lowest-index free slot, found by scanning from the top down
   always_comb begin
      free_idx = '0;
      has_free = 1'b0;
      for (int i = NUM_PIPES - 1; i >= 0; i--)
         if (!act_q[i]) begin
            free_idx = IDX_W'(i);
            has_free = 1'b1;
         end
   end
   // next state: collision freezes everything, otherwise scroll, retire, spawn and speed-up
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      gap_d   = gap_q;
      act_d   = act_q;
      last_d  = last_q;
      req_d   = 1'b0;
      inc_d   = 1'b0;
      spd_d   = spd_q;
      cnt_d   = cnt_q;
      retire  = 1'b0;
      if (live && bus.iCollision)
         state_d = OVER;
      else if (!live) begin
         if (bus.iStart) begin
            state_d = RUN;
            x_d     = '{default: '0};
            gap_d   = '{default: '0};
            act_d   = '0;
            last_d  = '0;
            spd_d   = 3'(SPEED_INIT);
            cnt_d   = '0;
         end
      end else begin
         if (bus.iFrame_Tick)
            for (int i = 0; i < NUM_PIPES; i++)
               if (act_q[i]) begin
                  if (x_q[i] <= spd_x) begin
                     act_d[i] = 1'b0;
                     x_d[i]   = '0;
                     retire   = 1'b1;
                  end else
                     x_d[i] = x_q[i] - spd_x;
               end
         if (accept) begin
            x_d[free_idx]   = X_W'(SCREEN_W);
            gap_d[free_idx] = gap_new;
            act_d[free_idx] = 1'b1;
            last_d          = free_idx;
            state_d         = RUN;
         end else if (state_q == SPAWN)
            req_d = 1'b1;
         else if (spawn_due)
            state_d = SPAWN;
         inc_d = retire;
         if (retire) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
            spd_d = (wrap && spd_q != 3'(SPEED_MAX)) ? spd_q + 3'd1 : spd_q;
         end
      end
   end
   // state registers with asynchronous active-low reset
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state_q <= IDLE;
         x_q     <= '{default: '0};
         gap_q   <= '{default: '0};
         act_q   <= '0;
         last_q  <= '0;
         req_q   <= 1'b0;
         inc_q   <= 1'b0;
         spd_q   <= 3'(SPEED_INIT);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         gap_q   <= gap_d;
         act_q   <= act_d;
         last_q  <= last_d;
         req_q   <= req_d;
         inc_q   <= inc_d;
         spd_q   <= spd_d;
         cnt_q   <= cnt_d;
      end
   end
   for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pack
      assign bus.oPipe_X[g*X_W +: X_W]       = x_q[g];
      assign bus.oPipe_Gap[g*GAP_W +: GAP_W] = gap_q[g];
   end
   assign bus.oPipe_Active = act_q;
   assign bus.oRnd_Req     = req_q;
   assign bus.oScore_Inc   = inc_q;
   assign bus.oSpeed       = spd_q;
   assign bus.oRunning     = live;
   assign bus.oGame_Over   = state_q == OVER;
endmodule

// File: tb/tb_pipe_scheduler.sv
// tb_pipe_scheduler: directed scenario tests of the pipe scheduler
module tb_pipe_scheduler;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   pipe_scheduler_if #(.NUM_PIPES(3), .X_W(10), .GAP_W(9)) bus ();
   pipe_scheduler dut (.iClk(clk), .iRst(rst_n), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   function automatic logic [9:0] xs(int i);
      return bus.oPipe_X[i*10 +: 10];
   endfunction
   function automatic logic [8:0] gs(int i);
      return bus.oPipe_Gap[i*9 +: 9];
   endfunction
   task automatic wait_req(string name);
      int n = 0;
      while (!bus.oRnd_Req && n < 8) begin
         step();
         n++;
      end
      tests++;
      if (bus.oRnd_Req !== 1'b1) begin
         fails++;
         $display("FAIL %s: oRnd_Req=%b after %0d cycles, required 1", name, bus.oRnd_Req, n);
      end
   endtask
   task automatic test_reset();
      bus.iStart = 0; bus.iFrame_Tick = 0; bus.iCollision = 0; bus.iRnd_Valid = 0; bus.iRnd_Data = '0;
      step(); step();
      rst_n = 1'b1;
      step();
      tests++;
      if ({bus.oRnd_Req, bus.oPipe_Active, bus.oScore_Inc, bus.oRunning, bus.oGame_Over} !== 7'b0) begin
         fails++;
         $display("FAIL reset_flags: req/act/inc/run/over=%b required 0000000",
                  {bus.oRnd_Req, bus.oPipe_Active, bus.oScore_Inc, bus.oRunning, bus.oGame_Over});
      end
      tests++;
      if (bus.oPipe_X !== 30'd0 || bus.oPipe_Gap !== 27'd0) begin
         fails++;
         $display("FAIL reset_slots: X=%h Gap=%h required 0", bus.oPipe_X, bus.oPipe_Gap);
      end
      tests++;
      if (bus.oSpeed !== 3'd1) begin
         fails++;
         $display("FAIL reset_speed: got %0d required 1", bus.oSpeed);
      end
   endtask
   task automatic test_start_spawn();
      bus.iStart = 1;
      step();
      bus.iStart = 0;
      tests++;
      if (bus.oRunning !== 1'b1) begin
         fails++;
         $display("FAIL start_running: got %b required 1", bus.oRunning);
      end
      wait_req("start_req");
      bus.iRnd_Valid = 1; bus.iRnd_Data = 9'd123;
      step();
      bus.iRnd_Valid = 0;
      tests++;
      if (xs(0) !== 10'd640 || gs(0) !== 9'd123 || bus.oPipe_Active !== 3'b001) begin
         fails++;
         $display("FAIL first_spawn: X0=%0d Gap0=%0d Act=%b required 640 123 001", xs(0), gs(0), bus.oPipe_Active);
      end
      tests++;
      if (bus.oRnd_Req !== 1'b0) begin
         fails++;
         $display("FAIL req_drop: got %b required 0", bus.oRnd_Req);
      end
   endtask
   task automatic test_scroll();
      int low = 0;
      bus.iFrame_Tick = 1;
      for (int i = 0; i < 219; i++) step();
      tests++;
      if (xs(0) !== 10'd421 || bus.oRnd_Req !== 1'b0) begin
         fails++;
         $display("FAIL scroll_219: X0=%0d req=%b required 421 0", xs(0), bus.oRnd_Req);
      end
      step();
      bus.iFrame_Tick = 0;
      tests++;
      if (xs(0) !== 10'd420) begin
         fails++;
         $display("FAIL scroll_220: X0=%0d required 420", xs(0));
      end
      wait_req("second_req");
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.oRnd_Req !== 1'b1) low++;
      end
      tests++;
      if (low != 0) begin
         fails++;
         $display("FAIL req_hold: req low on %0d of 10 cycles, required 0", low);
      end
      bus.iRnd_Valid = 1; bus.iRnd_Data = 9'd511;
      step();
      bus.iRnd_Valid = 0;
      tests++;
      if (xs(1) !== 10'd640 || gs(1) !== 9'd400 || bus.oPipe_Active !== 3'b011 || xs(0) !== 10'd420) begin
         fails++;
         $display("FAIL clamp_spawn: X1=%0d Gap1=%0d Act=%b X0=%0d required 640 400 011 420",
                  xs(1), gs(1), bus.oPipe_Active, xs(0));
      end
   endtask
   task automatic test_ignored_inputs();
      logic [26:0] gap_s = bus.oPipe_Gap;
      logic [29:0] x_s = bus.oPipe_X;
      bus.iRnd_Valid = 1; bus.iRnd_Data = 9'd77;
      step();
      bus.iRnd_Valid = 0;
      tests++;
      if (bus.oPipe_Active !== 3'b011 || bus.oPipe_Gap !== gap_s || bus.oRnd_Req !== 1'b0) begin
         fails++;
         $display("FAIL stray_valid: Act=%b Gap=%h req=%b required 011 %h 0", bus.oPipe_Active, bus.oPipe_Gap, bus.oRnd_Req, gap_s);
      end
      bus.iStart = 1;
      step();
      bus.iStart = 0;
      tests++;
      if (bus.oPipe_Active !== 3'b011 || bus.oPipe_X !== x_s || bus.oRunning !== 1'b1) begin
         fails++;
         $display("FAIL start_in_run: Act=%b X=%h run=%b required 011 %h 1", bus.oPipe_Active, bus.oPipe_X, bus.oRunning, x_s);
      end
   endtask
   task automatic test_speed();
      int pulses = 0, cyc = 0, bad = 0, exp_spd;
      logic [9:0] xp [3];
      logic [2:0] ap, sp;
      logic [8:0] d, dg;
      logic       ret;
      bus.iFrame_Tick = 1;
      while (pulses < 35 && cyc < 20000) begin
         for (int i = 0; i < 3; i++) xp[i] = xs(i);
         ap = bus.oPipe_Active;
         sp = bus.oSpeed;
         d = 9'(cyc * 37);
         dg = (d > 9'd400) ? 9'd400 : d;
         bus.iRnd_Valid = bus.oRnd_Req;
         bus.iRnd_Data = d;
         step();
         cyc++;
         ret = 1'b0;
         for (int i = 0; i < 3; i++) begin
            if (ap[i]) begin
               if (xp[i] <= 10'(sp)) begin
                  ret = 1'b1;
                  if (xs(i) !== 10'd0 || bus.oPipe_Active[i] !== 1'b0) bad++;
               end else if (xs(i) !== xp[i] - 10'(sp) || bus.oPipe_Active[i] !== 1'b1) bad++;
            end else if (bus.oPipe_Active[i] && (xs(i) !== 10'd640 || gs(i) !== dg)) bad++;
         end
         if (bus.oScore_Inc !== ret) bad++;
         if (bus.oScore_Inc === 1'b1) begin
            pulses++;
            exp_spd = (1 + pulses / 5 > 7) ? 7 : 1 + pulses / 5;
            tests++;
            if (bus.oSpeed !== 3'(exp_spd)) begin
               fails++;
               $display("FAIL speed_after_%0d: got %0d required %0d", pulses, bus.oSpeed, exp_spd);
            end
         end
      end
      bus.iRnd_Valid = 0;
      tests++;
      if (pulses != 35) begin
         fails++;
         $display("FAIL retire_count: got %0d pulses in %0d cycles, required 35", pulses, cyc);
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL scroll_model: %0d slot/pulse disagreements, required 0", bad);
      end
   endtask
   task automatic test_collision();
      int n = 0;
      logic [29:0] x_s;
      logic [2:0]  a_s;
      logic        near = 1'b0;
      while (!near && n < 2000) begin
         for (int i = 0; i < 3; i++)
            if (bus.oPipe_Active[i] && xs(i) <= 10'(bus.oSpeed)) near = 1'b1;
         if (!near) begin
            bus.iRnd_Valid = bus.oRnd_Req;
            bus.iRnd_Data = 9'd100;
            step();
            n++;
         end
      end
      bus.iRnd_Valid = 0;
      tests++;
      if (!near) begin
         fails++;
         $display("FAIL near_retire: no slot reached the left edge in %0d cycles", n);
      end
      x_s = bus.oPipe_X;
      a_s = bus.oPipe_Active;
      bus.iCollision = 1;
      step();
      bus.iCollision = 0;
      tests++;
      if (bus.oGame_Over !== 1'b1 || bus.oRunning !== 1'b0 || bus.oScore_Inc !== 1'b0 || bus.oRnd_Req !== 1'b0) begin
         fails++;
         $display("FAIL collide_state: over=%b run=%b inc=%b req=%b required 1 0 0 0",
                  bus.oGame_Over, bus.oRunning, bus.oScore_Inc, bus.oRnd_Req);
      end
      tests++;
      if (bus.oPipe_X !== x_s || bus.oPipe_Active !== a_s) begin
         fails++;
         $display("FAIL collide_frozen: X=%h Act=%b required %h %b", bus.oPipe_X, bus.oPipe_Active, x_s, a_s);
      end
      for (int i = 0; i < 5; i++) step();
      bus.iFrame_Tick = 0;
      tests++;
      if (bus.oPipe_X !== x_s || bus.oScore_Inc !== 1'b0 || bus.oGame_Over !== 1'b1) begin
         fails++;
         $display("FAIL over_frozen: X=%h inc=%b over=%b required %h 0 1", bus.oPipe_X, bus.oScore_Inc, bus.oGame_Over, x_s);
      end
      bus.iStart = 1;
      step();
      bus.iStart = 0;
      tests++;
      if (bus.oPipe_Active !== 3'b000 || bus.oPipe_X !== 30'd0 || bus.oSpeed !== 3'd1 || bus.oRunning !== 1'b1) begin
         fails++;
         $display("FAIL restart: Act=%b X=%h spd=%0d run=%b required 000 0 1 1",
                  bus.oPipe_Active, bus.oPipe_X, bus.oSpeed, bus.oRunning);
      end
   endtask
   task automatic test_reset_mid();
      wait_req("mid_req");
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (bus.oRnd_Req !== 1'b0 || bus.oPipe_Active !== 3'b000 || bus.oSpeed !== 3'd1 || bus.oRunning !== 1'b0) begin
         fails++;
         $display("FAIL async_reset: req=%b Act=%b spd=%0d run=%b required 0 000 1 0",
                  bus.oRnd_Req, bus.oPipe_Active, bus.oSpeed, bus.oRunning);
      end
      step(); step();
      rst_n = 1'b1;
      step();
      bus.iStart = 1;
      step();
      bus.iStart = 0;
      wait_req("post_reset_req");
      bus.iRnd_Valid = 1; bus.iRnd_Data = 9'd200;
      step();
      bus.iRnd_Valid = 0;
      tests++;
      if (xs(0) !== 10'd640 || gs(0) !== 9'd200 || bus.oPipe_Active !== 3'b001) begin
         fails++;
         $display("FAIL post_reset_spawn: X0=%0d Gap0=%0d Act=%b required 640 200 001", xs(0), gs(0), bus.oPipe_Active);
      end
   endtask
   initial begin
      test_reset();
      test_start_spawn();
      test_scroll();
      test_ignored_inputs();
      test_speed();
      test_collision();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
